ftdi_fifo_responder: RTL and testbench

Synthesizable device-side model of the FTDI asynchronous-FIFO (FT245-style) interface. It is the chip end of the same pin protocol the FPGA host interface drives. It presents RXF#/TXE# status and answers RD#/WR# strobes on a split 8-bit bus. Two internal byte queues carry data: a host-side producer fills the FPGA-bound queue, and a host-side consumer drains bytes the FPGA wrote. It is used for on-chip loopback and as the bus-functional partner in FTDI interface benches.

---
 rtl/ftdi_pkg.sv | 12 +
 rtl/byte_fifo.sv | 64 ++++++
 rtl/ftdi_fifo_responder.sv | 180 ++++++++++++++++++
 tb/tb_ftdi_fifo_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and default timing constants for the FT245-style device-side responder.
package ftdi_pkg;

  localparam int DATA_W           = 8;
  localparam int PRE_CNT_W        = 8;
  localparam int RXF_INACTIVE_DEF = 2;
  localparam int TXE_INACTIVE_DEF = 2;

  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_PRECHARGE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_PRECHARGE} wr_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO; dout reads 0 while empty, push when full and pop when empty are ignored.
module byte_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy gating on dout hides stale entries.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// Device-side model of the FTDI asynchronous FIFO pins: drives RXF#/TXE#, answers RD#/WR#,
// and bridges the FPGA bus to a host-side producer queue and consumer queue.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int RXF_INACTIVE = RXF_INACTIVE_DEF,
  parameter int TXE_INACTIVE = TXE_INACTIVE_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [7:0]             adbus_in,
  output logic                   rxf,
  output logic                   txe,
  output logic [7:0]             adbus_out,
  output logic                   adbus_oe,
  input  logic                   host_wr_valid,
  input  logic [7:0]             host_wr_data,
  output logic                   host_wr_ready,
  output logic                   host_rd_valid,
  output logic [7:0]             host_rd_data,
  input  logic                   host_rd_ack,
  output logic [$clog2(DEPTH):0] to_fpga_count,
  output logic [$clog2(DEPTH):0] from_fpga_count,
  output logic                   protocol_err
);

  rd_state_t             rd_state_q, rd_state_d;
  wr_state_t             wr_state_q, wr_state_d;
  logic                  rd_q, wr_q;
  logic                  rxf_q, rxf_d;
  logic                  txe_q, txe_d;
  logic                  err_q, err_d;
  logic [PRE_CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [PRE_CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [DATA_W-1:0]     cap_q, cap_d;
  logic                  rd_fall, rd_rise, wr_fall, wr_rise;
  logic                  to_pop, from_push;
  logic                  to_empty, to_full, from_empty, from_full;

  byte_fifo #(.DEPTH(DEPTH)) to_fpga_q (
    .clock (clock),
    .reset (reset),
    .push  (host_wr_valid),
    .pop   (to_pop),
    .din   (host_wr_data),
    .dout  (adbus_out),
    .empty (to_empty),
    .full  (to_full),
    .count (to_fpga_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) from_fpga_q (
    .clock (clock),
    .reset (reset),
    .push  (from_push),
    .pop   (host_rd_ack),
    .din   (cap_q),
    .dout  (host_rd_data),
    .empty (from_empty),
    .full  (from_full),
    .count (from_fpga_count)
  );

  assign rd_fall       = !rd && rd_q;
  assign rd_rise       = rd && !rd_q;
  assign wr_fall       = !wr && wr_q;
  assign wr_rise       = wr && !wr_q;
  assign adbus_oe      = !rd;
  assign rxf           = rxf_q;
  assign txe           = txe_q;
  assign protocol_err  = err_q;
  assign host_wr_ready = !to_full;
  assign host_rd_valid = !from_empty;

  always_comb begin
    rd_state_d = rd_state_q;
    rxf_d      = rxf_q;
    rcnt_d     = rcnt_q;
    to_pop     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        rxf_d = to_empty;
        if (rd_fall && !rxf_q) begin
          rd_state_d = R_ACTIVE;
          rxf_d      = 1'b1;
        end
      end
      R_ACTIVE: begin
        rxf_d = 1'b1;
        if (rd_rise) begin
          to_pop     = 1'b1;
          rd_state_d = R_PRECHARGE;
          rcnt_d     = PRE_CNT_W'(RXF_INACTIVE);
        end
      end
      R_PRECHARGE: begin
        rxf_d = 1'b1;
        if (rcnt_q <= PRE_CNT_W'(1)) begin
          rcnt_d     = '0;
          rd_state_d = R_IDLE;
        end else begin
          rcnt_d = rcnt_q - PRE_CNT_W'(1);
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    txe_d      = txe_q;
    wcnt_d     = wcnt_q;
    from_push  = 1'b0;
    cap_d      = wr ? cap_q : adbus_in;
    case (wr_state_q)
      W_IDLE: begin
        txe_d = from_full;
        if (wr_fall && !txe_q) begin
          wr_state_d = W_ACTIVE;
          txe_d      = 1'b1;
        end
      end
      W_ACTIVE: begin
        txe_d = 1'b1;
        if (wr_rise) begin
          from_push  = 1'b1;
          wr_state_d = W_PRECHARGE;
          wcnt_d     = PRE_CNT_W'(TXE_INACTIVE);
        end
      end
      W_PRECHARGE: begin
        txe_d = 1'b1;
        if (wcnt_q <= PRE_CNT_W'(1)) begin
          wcnt_d     = '0;
          wr_state_d = W_IDLE;
        end else begin
          wcnt_d = wcnt_q - PRE_CNT_W'(1);
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // A strobe falling while its status line is high, or both strobes low together, latches the error.
  always_comb begin
    err_d = err_q | (rd_fall && rxf_q) | (wr_fall && txe_q) | (!rd && !wr);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rxf_q      <= 1'b1;
      txe_q      <= 1'b1;
      err_q      <= 1'b0;
      rcnt_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      rd_q       <= rd;
      wr_q       <= wr;
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rxf_q      <= rxf_d;
      txe_q      <= txe_d;
      err_q      <= err_d;
      rcnt_q     <= rcnt_d;
      wcnt_q     <= wcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    cap_q <= cap_d;
  end

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Bench for ftdi_fifo_responder: directed protocol steps plus random traffic against queue models.
module tb_ftdi_fifo_responder;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rd = 1'b1;
  logic          wr = 1'b1;
  logic [7:0]    adbus_in = '0;
  logic          host_wr_valid = 1'b0;
  logic [7:0]    host_wr_data = '0;
  logic          host_rd_ack = 1'b0;
  logic          rxf, txe, adbus_oe, host_wr_ready, host_rd_valid, protocol_err;
  logic [7:0]    adbus_out, host_rd_data;
  logic [CW-1:0] to_fpga_count, from_fpga_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] mq_to[$];
  logic [7:0] mq_from[$];

  always #5 clock = ~clock;

  ftdi_fifo_responder #(
    .DEPTH(DEPTH), .RXF_INACTIVE(2), .TXE_INACTIVE(2)
  ) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .adbus_in(adbus_in),
    .rxf(rxf), .txe(txe), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ack(host_rd_ack),
    .to_fpga_count(to_fpga_count), .from_fpga_count(from_fpga_count),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; rd = 1'b1; wr = 1'b1; host_wr_valid = 1'b0; host_rd_ack = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    mq_to.delete();
    mq_from.delete();
  endtask

  // Between operations the status lines must reflect queue occupancy.
  task automatic settled();
    chk("idle_rxf", rxf, (mq_to.size() == 0));
    chk("idle_txe", txe, (mq_from.size() == DEPTH));
    chk("idle_to_cnt", to_fpga_count, mq_to.size());
    chk("idle_from_cnt", from_fpga_count, mq_from.size());
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wr_valid = 1'b1; host_wr_data = b;
    chk("push_ready", host_wr_ready, (mq_to.size() < DEPTH));
    tick();
    host_wr_valid = 1'b0;
    if (mq_to.size() < DEPTH) mq_to.push_back(b);
    chk("push_cnt", to_fpga_count, mq_to.size());
    tick();
  endtask

  task automatic fpga_read();
    logic [7:0] exp;
    exp = mq_to[0];
    chk("rd_rxf_pre", rxf, 0);
    rd = 1'b0; #1;
    chk("rd_oe", adbus_oe, 1);
    chk("rd_data", adbus_out, exp);
    tick();
    chk("rd_rxf_active", rxf, 1);
    tick();
    rd = 1'b1; #1;
    chk("rd_oe_off", adbus_oe, 0);
    tick();
    void'(mq_to.pop_front());
    chk("rd_cnt_after", to_fpga_count, mq_to.size());
    chk("rd_rxf_pc0", rxf, 1);
    tick(); chk("rd_rxf_pc1", rxf, 1);
    tick(); chk("rd_rxf_pc2", rxf, 1);
    tick(); chk("rd_rxf_reidle", rxf, (mq_to.size() == 0));
  endtask

  task automatic fpga_write(input logic [7:0] b, input int nlow);
    chk("wr_txe_pre", txe, 0);
    wr = 1'b0;
    adbus_in = 8'($urandom);
    for (int i = 0; i < nlow; i++) begin
      if (i == nlow - 1) adbus_in = b;
      tick();
      if (i == 0) chk("wr_txe_active", txe, 1);
    end
    wr = 1'b1;
    tick();
    mq_from.push_back(b);
    chk("wr_cnt_after", from_fpga_count, mq_from.size());
    chk("wr_hvalid", host_rd_valid, 1);
    chk("wr_hdata", host_rd_data, mq_from[0]);
    chk("wr_txe_pc0", txe, 1);
    tick(); chk("wr_txe_pc1", txe, 1);
    tick(); chk("wr_txe_pc2", txe, 1);
    tick(); chk("wr_txe_reidle", txe, (mq_from.size() == DEPTH));
  endtask

  task automatic host_pop();
    chk("pop_valid", host_rd_valid, 1);
    chk("pop_data", host_rd_data, mq_from[0]);
    host_rd_ack = 1'b1;
    tick();
    host_rd_ack = 1'b0;
    void'(mq_from.pop_front());
    chk("pop_cnt", from_fpga_count, mq_from.size());
    tick();
  endtask

  initial begin
    // Reset values while reset is held.
    tick(); tick();
    chk("rst_rxf", rxf, 1);
    chk("rst_txe", txe, 1);
    chk("rst_err", protocol_err, 0);
    chk("rst_to_cnt", to_fpga_count, 0);
    chk("rst_from_cnt", from_fpga_count, 0);
    chk("rst_adbus_out", adbus_out, 0);
    chk("rst_hdata", host_rd_data, 0);
    chk("rst_hready", host_wr_ready, 1);
    chk("rst_hvalid", host_rd_valid, 0);
    chk("rst_oe", adbus_oe, 0);
    reset = 1'b1;
    tick();
    chk("rel_txe", txe, 0);
    chk("rel_rxf", rxf, 1);

    // Host push 0xA5, then FPGA reads it.
    host_wr_valid = 1'b1; host_wr_data = 8'hA5;
    tick();
    host_wr_valid = 1'b0;
    mq_to.push_back(8'hA5);
    chk("a5_rxf_same", rxf, 1);
    chk("a5_cnt", to_fpga_count, 1);
    tick();
    chk("a5_rxf_low", rxf, 0);
    fpga_read();
    chk("a5_cnt_empty", to_fpga_count, 0);

    // FPGA writes 0x3C for two low cycles; host drains it.
    fpga_write(8'h3C, 2);
    chk("3c_hdata", host_rd_data, 8'h3C);
    host_pop();
    settled();

    // Random mixed traffic.
    for (int i = 0; i < 60; i++) begin
      int op;
      settled();
      op = $urandom_range(0, 3);
      case (op)
        0: host_push(8'($urandom));
        1: if (mq_to.size() != 0) fpga_read();
        2: if (mq_from.size() < DEPTH) fpga_write(8'($urandom), $urandom_range(1, 3));
        default: if (mq_from.size() != 0) host_pop();
      endcase
    end
    chk("rand_err", protocol_err, 0);

    // Fill the FPGA-written queue and overrun it.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) fpga_write(8'(i * 7 + 3), 1);
    chk("full_txe", txe, 1);
    chk("full_err_before", protocol_err, 0);
    wr = 1'b0; adbus_in = 8'hEE;
    tick();
    chk("full_err", protocol_err, 1);
    wr = 1'b1;
    tick(); tick();
    chk("full_cnt", from_fpga_count, DEPTH);
    chk("full_txe_hold", txe, 1);
    while (mq_from.size() != 0) host_pop();

    // Fill the FPGA-bound queue and push once more.
    for (int i = 0; i <= DEPTH; i++) host_push(8'($urandom));
    chk("to_full_cnt", to_fpga_count, DEPTH);
    chk("to_full_ready", host_wr_ready, 0);
    while (mq_to.size() != 0) fpga_read();

    // Loopback 0x00..0x0F in order.
    apply_reset();
    for (int i = 0; i < 16; i++) host_push(8'(i));
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = mq_to[0];
      fpga_read();
      fpga_write(b, 1);
    end
    for (int i = 0; i < 16; i++) begin
      chk("loop_order", host_rd_data, i);
      host_pop();
    end
    chk("loop_err", protocol_err, 0);

    // Read strobe with an empty queue.
    apply_reset();
    chk("empty_err_before", protocol_err, 0);
    rd = 1'b0; #1;
    chk("empty_oe", adbus_oe, 1);
    chk("empty_bus", adbus_out, 0);
    tick();
    chk("empty_err", protocol_err, 1);
    rd = 1'b1;
    tick(); tick();
    chk("empty_cnt", to_fpga_count, 0);
    chk("empty_rxf", rxf, 1);

    // Both strobes low together: flagged, yet both transfers complete.
    apply_reset();
    host_push(8'h5A);
    rd = 1'b0; wr = 1'b0; adbus_in = 8'hC3;
    tick();
    chk("both_err", protocol_err, 1);
    chk("both_rxf", rxf, 1);
    chk("both_txe", txe, 1);
    rd = 1'b1; wr = 1'b1;
    tick();
    void'(mq_to.pop_front());
    mq_from.push_back(8'hC3);
    chk("both_to_cnt", to_fpga_count, 0);
    chk("both_from_cnt", from_fpga_count, 1);
    chk("both_hdata", host_rd_data, 8'hC3);
    tick(); tick(); tick();
    settled();

    // Reset in the middle of a write, released with wr still low.
    apply_reset();
    host_push(8'h11);
    host_push(8'h22);
    wr = 1'b0; adbus_in = 8'h77;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    mq_to.delete();
    mq_from.delete();
    chk("mid_to_cnt", to_fpga_count, 0);
    chk("mid_from_cnt", from_fpga_count, 0);
    chk("mid_rxf", rxf, 1);
    chk("mid_txe", txe, 1);
    chk("mid_bus", adbus_out, 0);
    reset = 1'b1;
    tick();
    chk("mid_rel_err", protocol_err, 1);
    wr = 1'b1;
    tick(); tick(); tick();
    chk("mid_no_push", from_fpga_count, 0);
    chk("mid_hvalid", host_rd_valid, 0);
    chk("mid_txe_idle", txe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
